// File: rtl/dmi_cdc.sv
// rtl/dmi_cdc.sv - DMI bridge between the JTAG TCK domain and the Debug Module clock domain
// Optional macro DMI_CDC_SYNC3_EN selects 3-flop synchronisers instead of 2.
module dmi_cdc #(
    parameter int ABITS = 7
) (
    input  logic             tck_i,
    input  logic             clk_i,
    input  logic             trstn_i,
    input  logic             dmi_wr_i,
    input  logic             dmi_rd_i,
    input  logic [ABITS-1:0] dmi_ad_i,
    input  logic [31:0]      dmi_do_i,
    output logic [31:0]      dmi_di_o,
    output logic             dmi_busy_o,
    output logic             dmi_err_o,
    input  logic             dmi_reset_i,
    output logic             dm_req_valid_o,
    output logic             dm_req_wr_o,
    output logic [ABITS-1:0] dm_req_ad_o,
    output logic [31:0]      dm_req_data_o,
    input  logic             dm_rsp_valid_i,
    input  logic [31:0]      dm_rsp_data_i
);

`ifdef DMI_CDC_SYNC3_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif

    // TCK domain state
    logic             req_tgl;
    logic             hold_wr;
    logic [ABITS-1:0] hold_ad;
    logic [31:0]      hold_data;
    logic [N-1:0]     ack_sync;
    logic             ack_seen;
    logic             ack_edge;
    logic             one_hot;

    // clk domain state
    logic [N-1:0]     rst_sync;
    logic             clk_rstn;
    logic [N-1:0]     req_sync;
    logic             req_seen;
    logic             pending;
    logic             ack_tgl;
    logic [31:0]      rsp_q;

    assign one_hot  = dmi_wr_i ^ dmi_rd_i;
    assign ack_edge = ack_sync[N-1] ^ ack_seen;

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            req_tgl    <= 1'b0;
            hold_wr    <= 1'b0;
            hold_ad    <= '0;
            hold_data  <= '0;
            ack_sync   <= '0;
            ack_seen   <= 1'b0;
            dmi_di_o   <= '0;
            dmi_busy_o <= 1'b0;
            dmi_err_o  <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[N-2:0], ack_tgl};
            ack_seen <= ack_sync[N-1];
            // rsp_q is stable here: the DM side cannot update it again until a new request
            if (ack_edge) begin
                dmi_di_o   <= rsp_q;
                dmi_busy_o <= 1'b0;
            end
            if (one_hot && !dmi_busy_o) begin
                hold_wr    <= dmi_wr_i;
                hold_ad    <= dmi_ad_i;
                hold_data  <= dmi_do_i;
                req_tgl    <= ~req_tgl;
                dmi_busy_o <= 1'b1;
            end
            if (one_hot && dmi_busy_o) begin
                dmi_err_o <= 1'b1;
            end else if (dmi_reset_i) begin
                dmi_err_o <= 1'b0;
            end
        end
    end

    // Reset asserts asynchronously on the DM side but releases on clk_i
    always_ff @(posedge clk_i or negedge trstn_i) begin
        if (!trstn_i) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[N-2:0], 1'b1};
        end
    end

    assign clk_rstn = rst_sync[N-1];

    always_ff @(posedge clk_i or negedge clk_rstn) begin
        if (!clk_rstn) begin
            req_sync <= '0;
            req_seen <= 1'b0;
            pending  <= 1'b0;
            ack_tgl  <= 1'b0;
            rsp_q    <= '0;
        end else begin
            req_sync <= {req_sync[N-2:0], req_tgl};
            req_seen <= req_sync[N-1];
            if (dm_req_valid_o) begin
                pending <= 1'b1;
            end else if (dm_rsp_valid_i && pending) begin
                rsp_q   <= dm_rsp_data_i;
                ack_tgl <= ~ack_tgl;
                pending <= 1'b0;
            end
        end
    end

    // Hold registers are quasi-static while busy, so the DM side reads them directly
    assign dm_req_valid_o = req_sync[N-1] ^ req_seen;
    assign dm_req_wr_o    = hold_wr;
    assign dm_req_ad_o    = hold_ad;
    assign dm_req_data_o  = hold_data;

endmodule

// File: tb/tb_dmi_cdc.sv
// tb/tb_dmi_cdc.sv - directed self-checking bench for dmi_cdc
`timescale 1ns/100ps
module tb_dmi_cdc;

`ifdef DMI_CDC_SYNC3_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif

    logic        tck = 1'b0;
    logic        clk = 1'b0;
    logic        trstn = 1'b0;
    logic        dmi_wr_i = 1'b0;
    logic        dmi_rd_i = 1'b0;
    logic [6:0]  dmi_ad_i = '0;
    logic [31:0] dmi_do_i = '0;
    logic [31:0] dmi_di_o;
    logic        dmi_busy_o;
    logic        dmi_err_o;
    logic        dmi_reset_i = 1'b0;
    logic        dm_req_valid_o;
    logic        dm_req_wr_o;
    logic [6:0]  dm_req_ad_o;
    logic [31:0] dm_req_data_o;
    logic        dm_rsp_valid_i = 1'b0;
    logic [31:0] dm_rsp_data_i = '0;

    real tck_half = 50.0;
    real clk_half = 10.0;
    int  total = 0;
    int  bad = 0;
    int  vcount = 0;
    int  v0;
    int  lat;

    dmi_cdc #(.ABITS(7)) dut (
        .tck_i          (tck),
        .clk_i          (clk),
        .trstn_i        (trstn),
        .dmi_wr_i       (dmi_wr_i),
        .dmi_rd_i       (dmi_rd_i),
        .dmi_ad_i       (dmi_ad_i),
        .dmi_do_i       (dmi_do_i),
        .dmi_di_o       (dmi_di_o),
        .dmi_busy_o     (dmi_busy_o),
        .dmi_err_o      (dmi_err_o),
        .dmi_reset_i    (dmi_reset_i),
        .dm_req_valid_o (dm_req_valid_o),
        .dm_req_wr_o    (dm_req_wr_o),
        .dm_req_ad_o    (dm_req_ad_o),
        .dm_req_data_o  (dm_req_data_o),
        .dm_rsp_valid_i (dm_rsp_valid_i),
        .dm_rsp_data_i  (dm_rsp_data_i)
    );

    // clk edges sit on a .3 ns phase so they never coincide with integer-ns TCK edges
    initial begin
        forever begin
            #(tck_half);
            tck = ~tck;
        end
    end

    initial begin
        #7.3;
        forever begin
            clk = ~clk;
            #(clk_half);
        end
    end

    always @(negedge clk) begin
        if (dm_req_valid_o) vcount++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic wr, input logic rd, input logic rst, input logic [6:0] ad);
        @(negedge tck);
        dmi_wr_i = wr;
        dmi_rd_i = rd;
        dmi_reset_i = rst;
        dmi_ad_i = ad;
        @(negedge tck);
        dmi_wr_i = 1'b0;
        dmi_rd_i = 1'b0;
        dmi_reset_i = 1'b0;
    endtask

    // Returns 1 ns after the clk edge on which dm_req_valid_o was first seen high
    task automatic request(input logic wr, input logic [6:0] ad, input logic [31:0] d, output int clat);
        bit found;
        @(negedge tck);
        dmi_wr_i = wr;
        dmi_rd_i = ~wr;
        dmi_ad_i = ad;
        dmi_do_i = d;
        @(posedge tck);
        #1;
        dmi_wr_i = 1'b0;
        dmi_rd_i = 1'b0;
        clat = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            clat++;
            if (dm_req_valid_o) found = 1'b1;
        end
    endtask

    task automatic respond(input logic [31:0] d, output int tlat);
        bit done;
        @(negedge clk);
        @(negedge clk);
        dm_rsp_valid_i = 1'b1;
        dm_rsp_data_i = d;
        @(posedge clk);
        #1;
        dm_rsp_valid_i = 1'b0;
        tlat = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge tck);
            #1;
            tlat++;
            if (!dmi_busy_o) done = 1'b1;
        end
    endtask

    initial begin
        #200;
        chk("rst_di", dmi_di_o, 32'h0);
        chk("rst_busy", 32'(dmi_busy_o), 32'h0);
        chk("rst_err", 32'(dmi_err_o), 32'h0);
        chk("rst_valid", 32'(dm_req_valid_o), 32'h0);
        chk("rst_wr", 32'(dm_req_wr_o), 32'h0);
        chk("rst_ad", 32'(dm_req_ad_o), 32'h0);
        chk("rst_data", dm_req_data_o, 32'h0);
        @(negedge tck);
        trstn = 1'b1;
        repeat (N + 3) @(negedge clk);

        // Read at TCK 10 MHz, clk 50 MHz
        v0 = vcount;
        request(1'b0, 7'h11, 32'h0, lat);
        chk("rd_req_lat", 32'(lat), 32'(N));
        chk("rd_req_valid", 32'(dm_req_valid_o), 32'h1);
        chk("rd_req_wr", 32'(dm_req_wr_o), 32'h0);
        chk("rd_req_ad", 32'(dm_req_ad_o), 32'h11);
        chk("rd_busy", 32'(dmi_busy_o), 32'h1);
        @(posedge clk);
        #1;
        chk("rd_valid_width", 32'(dm_req_valid_o), 32'h0);
        respond(32'hCAFE0001, lat);
        chk("rd_rsp_lat", 32'(lat >= N + 1 && lat <= N + 2), 32'h1);
        chk("rd_di", dmi_di_o, 32'hCAFE0001);
        chk("rd_busy_clr", 32'(dmi_busy_o), 32'h0);
        chk("rd_pulses", 32'(vcount - v0), 32'h1);

        // Write, busy rejection and error clear
        v0 = vcount;
        request(1'b1, 7'h10, 32'h80000001, lat);
        chk("wr_req_wr", 32'(dm_req_wr_o), 32'h1);
        chk("wr_req_ad", 32'(dm_req_ad_o), 32'h10);
        chk("wr_req_data", dm_req_data_o, 32'h80000001);
        pulse(1'b0, 1'b1, 1'b0, 7'h22);
        repeat (20) @(negedge tck);
        chk("wr_busy_held", 32'(dmi_busy_o), 32'h1);
        chk("rej_err", 32'(dmi_err_o), 32'h1);
        pulse(1'b0, 1'b1, 1'b1, 7'h22);
        chk("rej_err_set_wins", 32'(dmi_err_o), 32'h1);
        chk("rej_hold_ad", 32'(dm_req_ad_o), 32'h10);
        respond(32'h5A5A0000, lat);
        chk("wr_busy_clr", 32'(dmi_busy_o), 32'h0);
        chk("wr_di", dmi_di_o, 32'h5A5A0000);
        repeat (5) @(negedge tck);
        chk("rej_no_pulse", 32'(vcount - v0), 32'h1);
        pulse(1'b0, 1'b0, 1'b1, 7'h00);
        chk("err_clr", 32'(dmi_err_o), 32'h0);

        // Both strobes together are ignored
        v0 = vcount;
        pulse(1'b1, 1'b1, 1'b0, 7'h33);
        repeat (10) @(negedge tck);
        chk("both_busy", 32'(dmi_busy_o), 32'h0);
        chk("both_err", 32'(dmi_err_o), 32'h0);
        chk("both_no_pulse", 32'(vcount - v0), 32'h0);

        // Read at TCK 20 MHz, clk ~1 MHz
        tck_half = 25.0;
        clk_half = 500.0;
        repeat (3) @(negedge clk);
        v0 = vcount;
        request(1'b0, 7'h05, 32'h0, lat);
        chk("r2_req_lat", 32'(lat), 32'(N));
        chk("r2_req_ad", 32'(dm_req_ad_o), 32'h05);
        respond(32'h0BADF00D, lat);
        chk("r2_rsp_lat", 32'(lat >= N + 1 && lat <= N + 2), 32'h1);
        chk("r2_di", dmi_di_o, 32'h0BADF00D);
        chk("r2_pulses", 32'(vcount - v0), 32'h1);
        @(negedge clk);
        dm_rsp_valid_i = 1'b1;
        dm_rsp_data_i = 32'hDEADBEEF;
        @(negedge clk);
        dm_rsp_valid_i = 1'b0;
        repeat (10) @(negedge tck);
        chk("spur_di", dmi_di_o, 32'h0BADF00D);
        chk("spur_busy", 32'(dmi_busy_o), 32'h0);

        // Reset while a request is pending on the DM side
        v0 = vcount;
        request(1'b1, 7'h7F, 32'hFFFFFFFF, lat);
        chk("mid_req_lat", 32'(lat), 32'(N));
        @(posedge clk);
        #5;
        trstn = 1'b0;
        #20;
        chk("mid_di", dmi_di_o, 32'h0);
        chk("mid_busy", 32'(dmi_busy_o), 32'h0);
        chk("mid_err", 32'(dmi_err_o), 32'h0);
        chk("mid_valid", 32'(dm_req_valid_o), 32'h0);
        chk("mid_wr", 32'(dm_req_wr_o), 32'h0);
        chk("mid_ad", 32'(dm_req_ad_o), 32'h0);
        chk("mid_data", dm_req_data_o, 32'h0);
        @(negedge tck);
        trstn = 1'b1;
        repeat (N + 2) @(negedge clk);
        dm_rsp_valid_i = 1'b1;
        dm_rsp_data_i = 32'h12345678;
        @(negedge clk);
        dm_rsp_valid_i = 1'b0;
        repeat (10) @(negedge tck);
        chk("late_rsp_di", dmi_di_o, 32'h0);
        chk("late_rsp_busy", 32'(dmi_busy_o), 32'h0);
        chk("late_no_pulse", 32'(vcount - v0), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
